bus_arbiter: RTL and testbench

- Three-master, one-slave arbiter for the shared memory bus.
- Master 0 is the CPU control sequencer; masters 1 and 2 are the video and DMA engines.
- Grants are round-robin and held for a whole multi-cycle transaction.
- Non-granted masters are stalled through their wait line. A slave that never releases wait is reported as a bus error.

---
 rtl/bus_arbiter_if.sv | 46 ++++
 rtl/bus_arbiter.sv | 149 ++++++++++++++
 tb/tb_bus_arbiter.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_if.sv
// Shared-memory bus bundle between the three masters, the arbiter and the slave.
//
// Handshake: a master raises m_read/m_write with address/data and holds them
// until it sees its m_wait low on a clock edge. That edge completes one beat.
// The master keeps its grant for as long as it holds a strobe. Dropping both
// strobes ends the transaction and frees the bus. The slave stretches a beat by
// holding s_wait high.
//
// Modport "master" is the arbiter's view, because the arbiter masters the slave
// bus. Modport "slave" is the view of the surrounding system: the masters'
// requests plus the slave's responses.
interface bus_arbiter_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);
  logic [2:0]          m_read;
  logic [2:0]          m_write;
  logic [3*AWIDTH-1:0] m_addr;
  logic [3*DWIDTH-1:0] m_writedata;
  logic [11:0]         m_byteenable;
  logic [2:0]          m_wait;
  logic [2:0]          m_error;
  logic [DWIDTH-1:0]   m_readdata;
  logic [2:0]          grant;
  logic                s_read;
  logic                s_write;
  logic [AWIDTH-1:0]   s_addr;
  logic [DWIDTH-1:0]   s_writedata;
  logic [3:0]          s_byteenable;
  logic [DWIDTH-1:0]   s_readdata;
  logic                s_wait;

  modport master (
    input  m_read, m_write, m_addr, m_writedata, m_byteenable,
    input  s_readdata, s_wait,
    output m_wait, m_error, m_readdata, grant,
    output s_read, s_write, s_addr, s_writedata, s_byteenable
  );

  modport slave (
    output m_read, m_write, m_addr, m_writedata, m_byteenable,
    output s_readdata, s_wait,
    input  m_wait, m_error, m_readdata, grant,
    input  s_read, s_write, s_addr, s_writedata, s_byteenable
  );
endinterface

// File: rtl/bus_arbiter.sv
// Three-master / one-slave round-robin arbiter for the shared memory bus.
// A grant is held for a whole transaction. Losers are stalled on m_wait.
// A slave that keeps s_wait high for TIMEOUT granted cycles causes a bus
// error on the owning master. The error is held until that master lets go.
module bus_arbiter #(
  parameter int AWIDTH  = 32,
  parameter int DWIDTH  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic             clock,
  input  logic             reset_n,
  bus_arbiter_if.master    bus,
  output logic [1:0]       o_dbg_state
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

  state_t          r_state;
  logic [2:0]      r_grant;
  logic [1:0]      r_last;    // last winner; also the current owner while granted
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_error;

  state_t          w_state_nxt;
  logic [2:0]      w_grant_nxt;
  logic [1:0]      w_last_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [2:0]      w_error_nxt;
  logic [2:0]      w_req;
  logic [1:0]      w_win;
  logic            w_owner_req;

  // First requester in the order last+1, last+2, last (mod 3).
  function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
    logic [1:0] idx;
    logic       found;
    rr_pick = 2'd0;
    found   = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      idx = 2'((int'(last) + k) % 3);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign w_req       = bus.m_read | bus.m_write;
  assign w_win       = rr_pick(w_req, r_last);
  assign w_owner_req = w_req[r_last];

  // State register. Reset is asynchronous, so the slave strobes drop at once.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_grant <= 3'b000;
      r_last  <= 2'd2;
      r_cnt   <= '0;
      r_error <= 3'b000;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
      r_error <= w_error_nxt;
    end
  end

  // Next-state logic: arbitration, release, and the slave-timeout watchdog.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    w_error_nxt = r_error;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (|w_req) begin
          w_grant_nxt = 3'b001 << w_win;
          w_last_nxt  = w_win;
          w_state_nxt = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (!w_owner_req) begin
          // Release wins over any pending request; arbitration happens in IDLE.
          w_state_nxt = ST_IDLE;
          w_grant_nxt = 3'b000;
          w_cnt_nxt   = '0;
        end else if (bus.s_wait) begin
          if (r_cnt == CW'(TIMEOUT - 1)) begin
            w_state_nxt = ST_ERROR;
            w_error_nxt = 3'b001 << r_last;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end else begin
          w_cnt_nxt = '0;
        end
      end
      ST_ERROR: begin
        w_cnt_nxt = '0;
        if (!w_owner_req) begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = 3'b000;
          w_error_nxt = 3'b000;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = 3'b000;
        w_cnt_nxt   = '0;
        w_error_nxt = 3'b000;
      end
    endcase
  end

  // Output mux: only an error-free owner reaches the slave; everyone else waits.
  always_comb begin
    bus.s_read       = 1'b0;
    bus.s_write      = 1'b0;
    bus.s_addr       = '0;
    bus.s_writedata  = '0;
    bus.s_byteenable = 4'b0000;
    bus.m_wait       = 3'b111;
    if (r_state == ST_GRANT) begin
      bus.s_read         = bus.m_read[r_last];
      bus.s_write        = bus.m_write[r_last];
      bus.s_addr         = bus.m_addr[r_last*AWIDTH +: AWIDTH];
      bus.s_writedata    = bus.m_writedata[r_last*DWIDTH +: DWIDTH];
      bus.s_byteenable   = bus.m_byteenable[r_last*4 +: 4];
      bus.m_wait[r_last] = bus.s_wait;
    end
  end

  assign bus.grant      = r_grant;
  assign bus.m_error    = r_error;
  assign bus.m_readdata = bus.s_readdata;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter. It uses a small reference model of the arbitration rules:
// an owner index, an error flag and a count of consecutive wait cycles.
module tb_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic       clock;
  logic       reset_n;
  logic [1:0] dbg_state;

  bus_arbiter_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

  bus_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .TIMEOUT(TO)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .bus        (bus),
    .o_dbg_state(dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [2:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got %0d vectors required completion", n_vec);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  int         mdl_owner = -1;   // -1: bus free
  logic       mdl_err   = 1'b0;
  int         mdl_last  = 2;
  int         mdl_waits = 0;
  int         mdl_cand;
  logic [2:0] mdl_req;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mdl_owner = -1;
      mdl_err   = 1'b0;
      mdl_last  = 2;
      mdl_waits = 0;
    end else begin
      mdl_req = bus.m_read | bus.m_write;
      if (mdl_owner < 0) begin
        if (mdl_req != 3'b000) begin
          for (int k = 1; k <= 3; k++) begin
            mdl_cand = (mdl_last + k) % 3;
            if (mdl_owner < 0 && mdl_req[mdl_cand]) mdl_owner = mdl_cand;
          end
          mdl_last  = mdl_owner;
          mdl_waits = 0;
        end
      end else if (!mdl_req[mdl_owner]) begin
        mdl_owner = -1;
        mdl_err   = 1'b0;
        mdl_waits = 0;
      end else if (!mdl_err) begin
        if (bus.s_wait) begin
          mdl_waits++;
          if (mdl_waits == TO) begin
            mdl_err   = 1'b1;
            mdl_waits = 0;
          end
        end else begin
          mdl_waits = 0;
        end
      end
    end
  end

  function automatic logic [2:0] exp_grant();
    return (mdl_owner >= 0) ? 3'(1 << mdl_owner) : 3'b000;
  endfunction

  function automatic logic [2:0] exp_error();
    return (mdl_owner >= 0 && mdl_err) ? 3'(1 << mdl_owner) : 3'b000;
  endfunction

  function automatic logic exp_active();
    return (mdl_owner >= 0) && !mdl_err;
  endfunction

  function automatic logic [2:0] exp_wait();
    logic [2:0] w;
    w = 3'b111;
    if (exp_active()) w[mdl_owner] = bus.s_wait;
    return w;
  endfunction

  // {s_read, s_write, s_byteenable, s_addr, s_writedata}
  function automatic logic [2+4+AW+DW-1:0] exp_sbus();
    if (!exp_active()) return '0;
    return {bus.m_read[mdl_owner], bus.m_write[mdl_owner],
            bus.m_byteenable[mdl_owner*4 +: 4],
            bus.m_addr[mdl_owner*AW +: AW],
            bus.m_writedata[mdl_owner*DW +: DW]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic clear_inputs();
    bus.m_read       = 3'b000;
    bus.m_write      = 3'b000;
    bus.m_addr       = '0;
    bus.m_writedata  = '0;
    bus.m_byteenable = 12'h000;
    bus.s_readdata   = '0;
    bus.s_wait       = 1'b0;
  endtask

  task automatic release_all();
    bus.m_read  = 3'b000;
    bus.m_write = 3'b000;
    bus.s_wait  = 1'b0;
    tick();
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_inputs();
    reset_n = 1'b1;
    #1;
    reset_n = 1'b0;
    tick();
    tick();
    n_vec++;
    if ({bus.grant, bus.m_error, bus.m_wait} !== {3'b000, 3'b000, 3'b111}) begin
      n_err++;
      $display("FAIL reset_outputs: got grant/err/wait=%b/%b/%b want 000/000/111",
               bus.grant, bus.m_error, bus.m_wait);
    end
    n_vec++;
    if ({bus.s_read, bus.s_write, bus.s_addr, bus.s_writedata, bus.s_byteenable} !== '0) begin
      n_err++;
      $display("FAIL reset_slave: got rd=%b wr=%b addr=%h wd=%h be=%b want all zero",
               bus.s_read, bus.s_write, bus.s_addr, bus.s_writedata, bus.s_byteenable);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_rotation();
    int held[3];
    int dropped[3];
    logic [2:0] g;
    logic [2:0] prev_g;
    logic [2:0] exp;
    int idle_run;
    int grants;
    held = '{0, 0, 0};
    dropped = '{0, 0, 0};
    prev_g = 3'b000;
    idle_run = 0;
    grants = 0;
    exp_q.delete();
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back(3'b001);
      exp_q.push_back(3'b010);
      exp_q.push_back(3'b100);
    end
    bus.m_read = 3'b111;
    for (int c = 0; c < 60 && grants < 6; c++) begin
      tick();
      g = bus.grant;
      n_vec++;
      if ((bus.m_wait | g) !== 3'b111) begin
        n_err++;
        $display("FAIL rotation_wait: cycle %0d got m_wait=%b with grant=%b want losers stalled", c, bus.m_wait, g);
      end
      if (g != 3'b000 && g != prev_g) begin
        exp = exp_q.pop_front();
        n_vec++;
        if (g !== exp) begin
          n_err++;
          $display("FAIL rotation_order: grant #%0d got %b want %b", grants, g, exp);
        end
        if (grants > 0) begin
          n_vec++;
          if (idle_run != 1) begin
            n_err++;
            $display("FAIL rotation_gap: got %0d idle cycles want 1", idle_run);
          end
        end
        grants++;
        idle_run = 0;
      end else if (g == 3'b000) begin
        idle_run++;
      end
      for (int i = 0; i < 3; i++) begin
        if (g[i]) begin
          held[i]++;
          if (held[i] == 3) begin
            bus.m_read[i] = 1'b0;
            held[i] = 0;
            dropped[i] = 1;
          end
        end else if (dropped[i] != 0) begin
          bus.m_read[i] = 1'b1;
          dropped[i] = 0;
        end
      end
      prev_g = g;
    end
    n_vec++;
    if (grants != 6) begin
      n_err++;
      $display("FAIL rotation_budget: got %0d grants want 6", grants);
    end
    release_all();
  endtask

  task automatic test_cpu_read();
    bus.m_read = 3'b001;
    bus.m_addr[0 +: AW] = 32'h0000_0100;
    bus.s_wait = 1'b1;
    #1;
    n_vec++;
    if (bus.grant !== 3'b000) begin
      n_err++;
      $display("FAIL cpu_latency: got grant=%b before edge want 000", bus.grant);
    end
    tick();
    n_vec++;
    if ({bus.grant, bus.s_read, bus.s_addr, bus.m_wait} !== {3'b001, 1'b1, 32'h100, 3'b111}) begin
      n_err++;
      $display("FAIL cpu_grant: got grant=%b rd=%b addr=%h wait=%b want 001/1/00000100/111",
               bus.grant, bus.s_read, bus.s_addr, bus.m_wait);
    end
    tick();
    bus.s_wait = 1'b0;
    bus.s_readdata = 32'hDEAD_BEEF;
    #1;
    n_vec++;
    if ({bus.m_wait, bus.m_readdata} !== {3'b110, 32'hDEAD_BEEF}) begin
      n_err++;
      $display("FAIL cpu_data: got wait=%b rdata=%h want 110/deadbeef", bus.m_wait, bus.m_readdata);
    end
    tick();
    bus.m_read = 3'b000;
    tick();
    n_vec++;
    if (bus.grant !== 3'b000) begin
      n_err++;
      $display("FAIL cpu_release: got grant=%b want 000", bus.grant);
    end
    release_all();
  endtask

  task automatic test_hold();
    bus.m_write = 3'b010;
    tick();
    bus.m_read = 3'b001;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_vec++;
      if ({bus.grant, bus.m_wait[0], bus.s_write} !== {3'b010, 1'b1, 1'b1}) begin
        n_err++;
        $display("FAIL hold_cycle: cycle %0d got grant=%b wait0=%b wr=%b want 010/1/1",
                 c, bus.grant, bus.m_wait[0], bus.s_write);
      end
    end
    bus.m_write = 3'b000;
    tick();
    n_vec++;
    if (bus.grant !== 3'b000) begin
      n_err++;
      $display("FAIL hold_dead: got grant=%b want 000", bus.grant);
    end
    tick();
    n_vec++;
    if (bus.grant !== 3'b001) begin
      n_err++;
      $display("FAIL hold_next: got grant=%b want 001", bus.grant);
    end
    release_all();
  endtask

  task automatic test_write_mux();
    bus.m_addr       = {32'h0000_2000, 32'hAAAA_0001, 32'hBBBB_0000};
    bus.m_writedata  = {32'h1234_5678, 32'h5555_5555, 32'h6666_6666};
    bus.m_byteenable = 12'b0011_1111_1100;
    bus.m_write      = 3'b100;
    tick();
    n_vec++;
    if ({bus.grant, bus.s_write, bus.s_read, bus.s_writedata, bus.s_byteenable, bus.s_addr}
        !== {3'b100, 1'b1, 1'b0, 32'h1234_5678, 4'b0011, 32'h0000_2000}) begin
      n_err++;
      $display("FAIL write_mux: got grant=%b wr=%b rd=%b wd=%h be=%b addr=%h want 100/1/0/12345678/0011/00002000",
               bus.grant, bus.s_write, bus.s_read, bus.s_writedata, bus.s_byteenable, bus.s_addr);
    end
    release_all();
  endtask

  task automatic test_timeout();
    bus.m_read = 3'b001;
    bus.s_wait = 1'b1;
    tick();
    for (int c = 2; c <= TO; c++) begin
      tick();
      n_vec++;
      if ({bus.m_error, bus.s_read, bus.grant} !== {3'b000, 1'b1, 3'b001}) begin
        n_err++;
        $display("FAIL timeout_early: wait cycle %0d got err=%b rd=%b grant=%b want 000/1/001",
                 c, bus.m_error, bus.s_read, bus.grant);
      end
    end
    bus.m_read[1] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_vec++;
      if ({bus.m_error, bus.s_read, bus.grant, bus.m_wait} !== {3'b001, 1'b0, 3'b001, 3'b111}) begin
        n_err++;
        $display("FAIL timeout_error: cycle %0d got err=%b rd=%b grant=%b wait=%b want 001/0/001/111",
                 c, bus.m_error, bus.s_read, bus.grant, bus.m_wait);
      end
    end
    bus.m_read[0] = 1'b0;
    bus.s_wait = 1'b0;
    tick();
    n_vec++;
    if ({bus.m_error, bus.grant} !== {3'b000, 3'b000}) begin
      n_err++;
      $display("FAIL timeout_clear: got err=%b grant=%b want 000/000", bus.m_error, bus.grant);
    end
    tick();
    n_vec++;
    if (bus.grant !== 3'b010) begin
      n_err++;
      $display("FAIL timeout_next: got grant=%b want 010", bus.grant);
    end
    release_all();
  endtask

  task automatic test_reset_mid();
    bus.m_read = 3'b010;
    bus.s_wait = 1'b1;
    tick();
    n_vec++;
    if ({bus.grant, bus.s_read} !== {3'b010, 1'b1}) begin
      n_err++;
      $display("FAIL rstmid_setup: got grant=%b rd=%b want 010/1", bus.grant, bus.s_read);
    end
    #1;
    reset_n = 1'b0;
    #1;
    n_vec++;
    if ({bus.grant, bus.s_read, bus.m_wait} !== {3'b000, 1'b0, 3'b111}) begin
      n_err++;
      $display("FAIL rstmid_async: got grant=%b rd=%b wait=%b want 000/0/111", bus.grant, bus.s_read, bus.m_wait);
    end
    bus.m_read = 3'b011;
    bus.s_wait = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    n_vec++;
    if (bus.grant !== 3'b001) begin
      n_err++;
      $display("FAIL rstmid_first: got grant=%b want 001", bus.grant);
    end
    release_all();
  endtask

  task automatic test_random();
    logic [1:0] rw;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          if (bus.m_read[i] | bus.m_write[i]) begin
            bus.m_read[i]  = 1'b0;
            bus.m_write[i] = 1'b0;
          end else begin
            rw = 2'($urandom_range(1, 3));
            bus.m_read[i]  = rw[0];
            bus.m_write[i] = rw[1];
          end
        end
      end
      bus.m_addr       = {$urandom, $urandom, $urandom};
      bus.m_writedata  = {$urandom, $urandom, $urandom};
      bus.m_byteenable = 12'($urandom);
      bus.s_readdata   = $urandom;
      bus.s_wait       = ($urandom_range(0, 9) < 7);
      #1;
      n_vec++;
      if ({bus.grant, bus.m_error, bus.m_wait} !== {exp_grant(), exp_error(), exp_wait()}) begin
        n_err++;
        $display("FAIL random_ctrl: cycle %0d got grant/err/wait=%b/%b/%b want %b/%b/%b",
                 c, bus.grant, bus.m_error, bus.m_wait, exp_grant(), exp_error(), exp_wait());
      end
      n_vec++;
      if ({bus.s_read, bus.s_write, bus.s_byteenable, bus.s_addr, bus.s_writedata} !== exp_sbus()) begin
        n_err++;
        $display("FAIL random_sbus: cycle %0d got %h want %h", c,
                 {bus.s_read, bus.s_write, bus.s_byteenable, bus.s_addr, bus.s_writedata}, exp_sbus());
      end
      n_vec++;
      if (bus.m_readdata !== bus.s_readdata) begin
        n_err++;
        $display("FAIL random_rdata: cycle %0d got %h want %h", c, bus.m_readdata, bus.s_readdata);
      end
      tick();
    end
    release_all();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_rotation();
    test_cpu_read();
    test_hold();
    test_write_mux();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
